fft_host_master: RTL and testbench

// - Host-side counterpart of the FFT AXI slave bridge. It is the initiator on the sample-load channel
//   (drives RDATA/RVALID, FFT returns RREADY) and the sink on the result channel (FFT drives WDATA/WVALID,

---
 rtl/fft_host_pkg.sv | 26 ++
 rtl/fft_reg_slice.sv | 39 +++
 rtl/fft_host_master.sv | 148 ++++++++++++++
 tb/tb_fft_host_master.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_host_pkg.sv
`default_nettype none
// ============================================================================
// fft_host_pkg -- shared types and helpers for the FFT host-side sequencer
// Revision: 1.0
// ============================================================================
package fft_host_pkg;

  localparam int FFT_SAMP_W = 12;
  localparam int FFT_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_CALC = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERR       = 3'd5
  } state_e;

  // Samples ride in the low half of the AXI word; the upper half is zero.
  function automatic logic [FFT_DATA_W-1:0] pack_sample(input logic [15:0] s);
    return {{(FFT_DATA_W-16){1'b0}}, s};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_reg_slice.sv
`default_nettype none
// ============================================================================
// fft_reg_slice -- one-entry valid/ready register stage
// Revision: 1.0
// ============================================================================
module fft_reg_slice #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] data_q;
  logic         valid_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      data_q  <= in_data_i;
      valid_q <= 1'b1;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_host_master.sv
`default_nettype none
// ============================================================================
// fft_host_master -- sequences one FFT transform: load N samples, drain N bins
// Revision: 1.0
// ============================================================================
module fft_host_master
  import fft_host_pkg::*;
#(
  parameter int SAMP_W  = FFT_SAMP_W,
  parameter int DATA_W  = FFT_DATA_W,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [SAMP_W-1:0] cfg_samp_num,
  input  logic              cfg_mac,
  input  logic [15:0]       src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] RDATA,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [SAMP_W-1:0] SAMP_NUMBER,
  output logic              MAC_nRADIX,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = SAMP_W + 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     sent_q, sent_d, recv_q, recv_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [SAMP_W-1:0] samp_q, samp_d;
  logic              mac_q, mac_d;
  logic [CW-1:0]     n_full;
  logic              load_slot, res_slot, w_hs, start_ok, in_calc;

  assign n_full    = CW'(samp_q);
  assign in_calc   = (state_q == ST_WAIT_CALC) || (state_q == ST_DRAIN);
  // A beat parked in the load slice already counts toward N.
  assign src_ready = (state_q == ST_LOAD) && ((sent_q + CW'(RVALID)) < n_full) && load_slot;
  assign WREADY    = in_calc && (recv_q < n_full) && res_slot;
  assign w_hs      = WVALID && WREADY;
  assign start_ok  = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});

  assign SAMP_NUMBER = samp_q;
  assign MAC_nRADIX  = mac_q;
  assign busy        = (state_q == ST_LOAD) || in_calc;
  assign done        = (state_q == ST_DONE);
  assign err         = (state_q == ST_ERR);

  fft_reg_slice #(.W(DATA_W)) u_load_slice (
    .clk_i       (clk),
    .rst_i       (Reset),
    .in_data_i   (DATA_W'(pack_sample(src_data))),
    .in_valid_i  (src_valid && src_ready),
    .in_ready_o  (load_slot),
    .out_data_o  (RDATA),
    .out_valid_o (RVALID),
    .out_ready_i (RREADY)
  );

  fft_reg_slice #(.W(DATA_W)) u_res_slice (
    .clk_i       (clk),
    .rst_i       (Reset),
    .in_data_i   (WDATA),
    .in_valid_i  (w_hs),
    .in_ready_o  (res_slot),
    .out_data_o  (res_data),
    .out_valid_o (res_valid),
    .out_ready_i (res_ready)
  );

  always_comb begin
    state_d = state_q;
    sent_d  = sent_q;
    recv_d  = recv_q;
    idle_d  = idle_q;
    samp_d  = samp_q;
    mac_d   = mac_q;

    if (RVALID && RREADY) sent_d = sent_q + CW'(1);
    if (w_hs)             recv_d = recv_q + CW'(1);

    // Only cycles where we could have taken a beat count as idle.
    if (!in_calc || w_hs) begin
      idle_d = '0;
    end else if (WREADY && (idle_q != IW'(TIMEOUT))) begin
      idle_d = idle_q + IW'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_ok) begin
          samp_d  = cfg_samp_num;
          mac_d   = cfg_mac;
          sent_d  = '0;
          recv_d  = '0;
          state_d = (cfg_samp_num == '0) ? ST_DONE : ST_LOAD;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (sent_d == n_full) state_d = ST_WAIT_CALC;
      end
      ST_WAIT_CALC: begin
        if (w_hs)                             state_d = ST_DRAIN;
        else if (idle_q == IW'(TIMEOUT))      state_d = ST_ERR;
      end
      ST_DRAIN: begin
        if ((recv_q == n_full) && (!res_valid || res_ready)) state_d = ST_DONE;
        else if (!w_hs && (idle_q == IW'(TIMEOUT)))         state_d = ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      sent_q  <= '0;
      recv_q  <= '0;
      idle_q  <= '0;
      samp_q  <= '0;
      mac_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      recv_q  <= recv_d;
      idle_q  <= idle_d;
      samp_q  <= samp_d;
      mac_q   <= mac_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_host_master.sv
`default_nettype none
// ============================================================================
// tb_fft_host_master -- scoreboard bench for the FFT host sequencer
// Revision: 1.0
// ============================================================================
module tb_fft_host_master;

  localparam int SW = 12;
  localparam int DW = 32;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          Reset, start, cfg_mac, src_valid, src_ready;
  logic [SW-1:0] cfg_samp_num, SAMP_NUMBER;
  logic [15:0]   src_data;
  logic [DW-1:0] res_data, RDATA, WDATA;
  logic          res_valid, res_ready, RVALID, RREADY, WVALID, WREADY;
  logic          MAC_nRADIX, busy, done, err;

  always #5 clk = ~clk;

  fft_host_master #(.SAMP_W(SW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .Reset(Reset), .start(start), .cfg_samp_num(cfg_samp_num), .cfg_mac(cfg_mac),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .SAMP_NUMBER(SAMP_NUMBER), .MAC_nRADIX(MAC_nRADIX),
    .busy(busy), .done(done), .err(err)
  );

  int vectors = 0, miscompares = 0, cyc = 0;
  int ld_hs = 0, res_hs = 0, done_cnt = 0, first_ld_cyc = 0, last_ld_cyc = 0;
  logic ld_mark = 1'b0, rr_toggle = 1'b0, rr_level = 1'b1;
  logic [DW-1:0] exp_rq[$], exp_wq[$];
  logic [DW-1:0] r_prev = '0, w_prev = '0;
  logic r_stall = 1'b0, w_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [DW-1:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: actual=%0h expected=<no beat>", name, act);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FFT-side RREADY pattern: steady level or toggling every cycle.
  initial begin
    RREADY = 1'b0;
    forever begin
      @(posedge clk); #1;
      RREADY = rr_toggle ? ~RREADY : rr_level;
    end
  end

  // Monitor: checks every handshake against the scoreboard and stability under stall.
  always @(negedge clk) begin
    if (Reset) begin
      r_stall = 1'b0;
      w_stall = 1'b0;
    end else begin
      if (r_stall) begin
        check("rdata_held", RDATA, r_prev);
        check("rvalid_held", RVALID, 1);
      end
      if (RVALID && RREADY) begin
        ld_hs++;
        last_ld_cyc = cyc;
        if (ld_mark) begin first_ld_cyc = cyc; ld_mark = 1'b0; end
        if (exp_rq.size() == 0) unexpected("rdata_beat", RDATA);
        else check("rdata", RDATA, exp_rq.pop_front());
      end
      r_stall = RVALID && !RREADY;
      r_prev  = RDATA;

      if (w_stall) begin
        check("res_data_held", res_data, w_prev);
        check("res_valid_held", res_valid, 1);
      end
      if (res_valid && res_ready) begin
        res_hs++;
        if (exp_wq.size() == 0) unexpected("res_beat", res_data);
        else check("res_data", res_data, exp_wq.pop_front());
      end
      w_stall = res_valid && !res_ready;
      w_prev  = res_data;
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int n, input logic mac);
    cfg_samp_num = SW'(n);
    cfg_mac      = mac;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic feed(input int n, input logic [15:0] base);
    int i = 0;
    int g = 0;
    src_valid = 1'b1;
    src_data  = base;
    while (i < n && g < 500) begin
      @(negedge clk);
      if (src_ready) begin
        exp_rq.push_back({16'h0000, base + 16'(i)});
        i++;
      end
      tick();
      g++;
      src_data = base + 16'(i);
    end
    src_valid = 1'b0;
    check("feed_beats", i, n);
  endtask

  task automatic fft_send(input int n, input logic [DW-1:0] base);
    int i = 0;
    int g = 0;
    WVALID = 1'b1;
    WDATA  = base;
    while (i < n && g < 500) begin
      @(negedge clk);
      if (WREADY) begin
        exp_wq.push_back(base + DW'(i));
        i++;
      end
      tick();
      g++;
      WDATA = base + DW'(i);
    end
    WVALID = 1'b0;
    check("fft_send_beats", i, n);
  endtask

  task automatic wait_done(input string name, input int d0);
    int g = 0;
    while (done_cnt == d0 && g < 400) begin tick(); g++; end
    tick(); tick();
    check(name, done_cnt - d0, 1);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    int d0, b0, r0;
    Reset = 1'b1; start = 1'b0; cfg_samp_num = '0; cfg_mac = 1'b0;
    src_data = '0; src_valid = 1'b0; res_ready = 1'b1; WDATA = '0; WVALID = 1'b0;
    repeat (3) tick();
    check("rst_flags", {RVALID, WREADY, src_ready, res_valid, busy, done, err, SAMP_NUMBER, MAC_nRADIX}, 0);
    check("rst_data", {RDATA, res_data}, 0);
    Reset = 1'b0;
    tick();

    // N=8 back-to-back load, result burst 20 cycles after start.
    d0 = done_cnt; b0 = ld_hs; r0 = res_hs; ld_mark = 1'b1;
    do_start(8, 1'b1);
    check("cfg_n8", {SAMP_NUMBER, MAC_nRADIX}, {12'd8, 1'b1});
    check("busy_n8", busy, 1);
    fork
      feed(8, 16'h0100);
      begin repeat (19) tick(); fft_send(8, 32'hA000_0010); end
    join
    wait_done("done_n8", d0);
    check("ld_count_n8", ld_hs - b0, 8);
    check("ld_consecutive", last_ld_cyc - first_ld_cyc, 7);
    check("res_count_n8", res_hs - r0, 8);

    // N=4 with RREADY toggling.
    rr_toggle = 1'b1;
    d0 = done_cnt; b0 = ld_hs;
    do_start(4, 1'b0);
    fork
      feed(4, 16'h0BEE);
      begin repeat (25) tick(); fft_send(4, 32'h1234_5670); end
    join
    wait_done("done_toggle", d0);
    check("ld_count_toggle", ld_hs - b0, 4);
    rr_toggle = 1'b0; rr_level = 1'b1;
    tick();

    // N=4 with the result sink stalled for 10 cycles during drain.
    d0 = done_cnt; r0 = res_hs;
    do_start(4, 1'b1);
    fork
      feed(4, 16'h7FF0);
      begin repeat (12) tick(); fft_send(4, 32'hC0DE_0000); end
      begin
        int g = 0;
        while (!res_valid && g < 200) begin tick(); g++; end
        tick();
        res_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          check("stall_wready", WREADY, 0);
          check("stall_res_valid", res_valid, 1);
          tick();
        end
        check("stall_no_err", err, 0);
        res_ready = 1'b1;
      end
    join
    wait_done("done_stall", d0);
    check("res_count_stall", res_hs - r0, 4);

    // Timeout: N=2 loaded, FFT never answers.
    do_start(2, 1'b0);
    feed(2, 16'h0042);
    begin
      int g = 0;
      while (!err && g < 200) begin tick(); g++; end
    end
    check("timeout_cycles", cyc - last_ld_cyc, TO + 2);
    check("timeout_err", err, 1);
    check("timeout_busy", busy, 0);
    repeat (3) tick();
    check("err_sticky", err, 1);

    // N=0 start clears err and pulses done with no load beats.
    d0 = done_cnt; b0 = ld_hs;
    do_start(0, 1'b1);
    check("zero_err_clear", err, 0);
    wait_done("done_zero", d0);
    check("zero_no_beats", ld_hs - b0, 0);

    // start during LOAD is ignored.
    rr_level = 1'b0;
    d0 = done_cnt;
    do_start(3, 1'b0);
    tick(); tick();
    do_start(7, 1'b1);
    tick();
    check("ignore_cfg", {SAMP_NUMBER, MAC_nRADIX}, {12'd3, 1'b0});
    check("ignore_busy", busy, 1);
    rr_level = 1'b1;
    fork
      feed(3, 16'h3000);
      begin repeat (15) tick(); fft_send(3, 32'h5555_0000); end
    join
    wait_done("done_ignore", d0);

    // Reset after 3 of 8 samples have been sent.
    b0 = ld_hs;
    do_start(8, 1'b0);
    feed(3, 16'h0900);
    tick();
    check("pre_rst_sent", ld_hs - b0, 3);
    Reset = 1'b1;
    tick();
    check("midrst_flags", {RVALID, WREADY, src_ready, res_valid, busy, done, err, SAMP_NUMBER, MAC_nRADIX}, 0);
    check("midrst_data", {RDATA, res_data}, 0);
    exp_rq.delete();
    exp_wq.delete();
    Reset = 1'b0;
    tick();
    d0 = done_cnt; b0 = ld_hs;
    do_start(2, 1'b1);
    fork
      feed(2, 16'h0ABC);
      begin repeat (10) tick(); fft_send(2, 32'hDEAD_0000); end
    join
    wait_done("done_after_rst", d0);
    check("ld_count_after_rst", ld_hs - b0, 2);

    repeat (3) tick();
    check("rq_empty", exp_rq.size(), 0);
    check("wq_empty", exp_wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
